// File: rtl/capture_arbiter.sv
// Round-robin arbiter in front of a shared capture/AND datapath (operand flops, B buffer, result flop).
// Optional result-timeout is enabled by defining CAPTURE_TIMEOUT_EN.
module capture_arbiter #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] a_in,
  input  logic [NREQ*WIDTH-1:0] b_in,
  output logic [NREQ-1:0]       gnt,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [2:0]            out_id,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam int unsigned IW = $clog2(NREQ);

  typedef enum logic [1:0] {StIdle, StLoad, StEval, StResult} state_e;

  state_e           r_state;
  logic [IW-1:0]    r_ptr;
  logic [IW-1:0]    r_id;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_b_buf;
  logic [WIDTH-1:0] r_data;
  logic [2:0]       r_out_id;
  logic             r_valid;

  logic             w_found;
  logic [IW-1:0]    w_win;
  logic [IW-1:0]    w_ptr_nxt;
  logic [NREQ-1:0]  w_gnt;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;

`ifdef CAPTURE_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] r_cnt;
  logic          r_tmo;
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYC == 0);
`endif

  // Lowest set bit at or above ptr wins; if none, the lowest set bit overall (wrap).
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_found = 1'b1;
        w_win   = IW'(i);
      end
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i] && (IW'(i) >= r_ptr)) w_win = IW'(i);
    end
  end

  assign w_ptr_nxt = (w_win == IW'(NREQ - 1)) ? '0 : w_win + 1'b1;

  // Grant is gated by rst_n so it reads 0 during reset even with requests pending.
  always_comb begin
    w_gnt = '0;
    w_a   = '0;
    w_b   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == IW'(i)) begin
        w_a = a_in[i*WIDTH +: WIDTH];
        w_b = b_in[i*WIDTH +: WIDTH];
      end
    end
    if (rst_n && (r_state == StIdle) && w_found) w_gnt[w_win] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_ptr    <= '0;
      r_id     <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_b_buf  <= '0;
      r_data   <= '0;
      r_out_id <= '0;
      r_valid  <= 1'b0;
`ifdef CAPTURE_TIMEOUT_EN
      r_cnt    <= '0;
      r_tmo    <= 1'b0;
`endif
    end else begin
`ifdef CAPTURE_TIMEOUT_EN
      r_tmo <= 1'b0;
`endif
      unique case (r_state)
        StIdle: begin
          if (w_found) begin
            r_op_a  <= w_a;
            r_op_b  <= w_b;
            r_id    <= w_win;
            r_ptr   <= w_ptr_nxt;
            r_state <= StLoad;
          end
        end
        StLoad: begin
          r_b_buf <= r_op_b;
          r_state <= StEval;
        end
        StEval: begin
          r_data   <= r_op_a & r_b_buf;
          r_out_id <= 3'(r_id);
          r_valid  <= 1'b1;
          r_state  <= StResult;
`ifdef CAPTURE_TIMEOUT_EN
          r_cnt    <= '0;
`endif
        end
        StResult: begin
          if (out_ready) begin
            r_valid <= 1'b0;
            r_state <= StIdle;
`ifdef CAPTURE_TIMEOUT_EN
          end else if (r_cnt == CW'(TIMEOUT_CYC - 1)) begin
            r_valid <= 1'b0;
            r_tmo   <= 1'b1;
            r_state <= StIdle;
          end else begin
            r_cnt <= r_cnt + 1'b1;
`endif
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign gnt       = w_gnt;
  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_id    = r_out_id;
  assign busy      = (r_state != StIdle);
`ifdef CAPTURE_TIMEOUT_EN
  assign timeout_err = r_tmo;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: doc/capture_arbiter.md
Name: capture_arbiter

Overview:
- Shares one register-capture/AND datapath between NREQ requesters.
- The datapath is: operand flops, a buffer stage on the B path, a two-input AND, and a result flop.
- The block arbitrates round-robin, loads the winner's operands, sequences them through the datapath, and presents the result with valid/ready.
- Sits between requester logic and the shared capture/combine resource.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, operand/result width in bits.
- TIMEOUT_CYC, 16, RESULT-state cycles to wait for out_ready before dropping the result (used only with the optional feature).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NREQ  per-requester request, level; held until gnt.
- a_in  input  NREQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH].
- b_in  input  NREQ*WIDTH  operand B, same packing.
- gnt  output  NREQ  one-hot grant pulse; operands are sampled on this cycle's edge.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  WIDTH  A & B of the granted requester.
- out_id  output  3  index of the requester that owns out_data.
- busy  output  1  high in any state other than IDLE.
- timeout_err  output  1  one-cycle pulse when a result is dropped.

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (rst_n).
  - While rst_n is low, all state is cleared immediately: state=IDLE, gnt=0, out_valid=0, out_data=0, out_id=0, busy=0, timeout_err=0, RR pointer=0, timeout counter=0.
- FSM states: IDLE, LOAD, EVAL, RESULT.
- IDLE:
  - gnt is combinational and asserted only in IDLE with req!=0.
  - Winner = first set bit of req searching upward (with wrap) from ptr.
  - On the edge ending the grant cycle: latch a_in/b_in of the winner into the operand regs, latch the winner index into id, set ptr=(winner+1) mod NREQ, go to LOAD.
  - With req==0: stay in IDLE, gnt=0.
- LOAD: B operand passes through the buffer stage register; go to EVAL.
- EVAL: result reg <= opA & opB; out_id <= id; go to RESULT.
- RESULT:
  - out_valid=1; out_data and out_id are stable until the handshake.
  - On out_valid & out_ready: out_valid drops on the next edge, go to IDLE.
- Latency and throughput:
  - Grant in cycle T gives out_valid high in cycle T+3.
  - Maximum throughput is one transaction per 4 cycles.
  - No grant in the handshake cycle; the earliest next gnt is the cycle after the return to IDLE.
- req handling:
  - req deasserted before grant: no grant is issued; no error.
  - req changes while busy: ignored; sampled only in IDLE.
  - Requester i's operands are sampled only on its grant cycle. Later a_in/b_in changes must not affect out_data.
- Round-robin: after granting i, requester i has lowest priority on the next grant.
- Reset asserted mid-transaction: the transaction is lost with no output. After release the block is IDLE with ptr=0.
- out_id is zero-extended from the internal index width.

Optional Feature:
- Macro: CAPTURE_TIMEOUT_EN.
- Defined:
  - A counter runs in RESULT. If out_ready stays low for TIMEOUT_CYC consecutive RESULT cycles, the block drops out_valid, pulses timeout_err for 1 cycle, and goes to IDLE.
  - out_valid is high for exactly TIMEOUT_CYC cycles.
  - If out_ready rises on the final cycle, the handshake wins and there is no error.
- Undefined:
  - RESULT holds indefinitely until out_ready.
  - timeout_err is tied 0; the port is always present.

Test Plan:
- Single request: req=4'b0010, a_in[1]=8'hF0, b_in[1]=8'h3C, out_ready=1.
  - Response: gnt=4'b0010 at T; out_valid at T+3 with out_data=8'h30, out_id=1; busy low at T+4.
- All requesting continuously: req=4'b1111, out_ready=1.
  - Response: grant order 0,1,2,3,0, each grant 4 cycles apart.
- Backpressure: out_ready=0 for 5 cycles, then 1.
  - Response: out_valid held with out_data/out_id constant; accepted on cycle 6; no gnt during the hold.
- Operand change after grant: a_in[2] changes 8'hFF to 8'h00 at T+1.
  - Response: out_data = 8'hFF & b_in[2] as sampled at T.
- Async reset while in EVAL:
  - Response: all outputs 0 immediately without a clock edge; after release, req=4'b1000 is granted to requester 3 and requester 0 has priority next.
- CAPTURE_TIMEOUT_EN, TIMEOUT_CYC=16, out_ready=0:
  - Response: out_valid high for exactly 16 cycles, timeout_err pulses once, FSM returns to IDLE.
  - Repeat with out_ready=1 on the 16th cycle: normal accept, timeout_err stays 0.
